// File: rtl/led_color_buffer.sv
// Double-buffered RGB colour store for the multiplexed LED PWM scanner.
// Latency: write/commit take effect at a frame boundary; read pipeline is 2 cycles.
// Backpressure: wr_ready_o drops while a commit is pending, until the next frame_start_i.
//
// Ports:
//   clk_i, rst_i              clock and asynchronous active-high reset
//   wr_valid_i / wr_ready_o   write handshake; wr_led_i, wr_r_i, wr_g_i, wr_b_i carry the data
//   wr_err_o                  1-cycle pulse after an accepted write with an out-of-range LED index
//   commit_req_i              level request to publish the back bank
//   commit_ack_o              1-cycle pulse, the cycle after the bank swap
//   frame_start_i             PWM frame boundary pulse from the scanner
//   rd_chan_i                 physical sink phase being scanned (3 = all off)
//   bright_i                  global brightness, 255 = full scale
//   level_bus_o               byte l = scaled PWM level of LED l on sink rd_chan_i
module led_color_buffer #(
   parameter int NUM_LEDS = 11,
   // Per LED l, bits [6l+2p +: 2] give the logical colour driven on physical
   // sink p (0=R, 1=G, 2=B, 3=off). Listed LED10 down to LED0.
   parameter logic [6*NUM_LEDS-1:0] CHAN_MAP = {
      6'h24, 6'h24, 6'h21, 6'h21, 6'h06, 6'h06,
      6'h24, 6'h06, 6'h24, 6'h06, 6'h24
   }
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [3:0]            wr_led_i,
   input  logic [7:0]            wr_r_i,
   input  logic [7:0]            wr_g_i,
   input  logic [7:0]            wr_b_i,
   output logic                  wr_err_o,
   input  logic                  commit_req_i,
   output logic                  commit_ack_o,
   input  logic                  frame_start_i,
   input  logic [1:0]            rd_chan_i,
   input  logic [7:0]            bright_i,
   output logic [8*NUM_LEDS-1:0] level_bus_o
);

   localparam logic [3:0] LED_LIMIT = 4'(NUM_LEDS);

   // Storage: [bank][led][colour], colour 0=R, 1=G, 2=B.
   logic [7:0] bank_q [2][NUM_LEDS][3];
   logic [7:0] bank_d [2][NUM_LEDS][3];

   logic front_q;
   logic pending_q, pending_d;
   logic wr_err_q, wr_err_d;
   logic commit_ack_q;

   // Read pipeline registers.
   logic [7:0]            sel_q [NUM_LEDS];
   logic [7:0]            sel_d [NUM_LEDS];
   logic [7:0]            bright_q;
   logic [8*NUM_LEDS-1:0] level_q, level_d;

   logic wr_fire;
   logic wr_in_range;
   logic swap;
   logic back;

   assign back        = ~front_q;
   assign wr_fire     = wr_valid_i && !pending_q;
   assign wr_in_range = (wr_led_i < LED_LIMIT);
   // pending_q and frame_start_i are both pre-edge values, so a commit_req
   // arriving together with frame_start_i cannot swap in the same cycle.
   assign swap        = pending_q && frame_start_i;

   assign wr_ready_o   = !pending_q;
   assign wr_err_o     = wr_err_q;
   assign commit_ack_o = commit_ack_q;
   assign level_bus_o  = level_q;

   // ------------------------------------------------------------------
   // Commit control
   // ------------------------------------------------------------------
   always_comb begin
      pending_d = pending_q;
      if (swap) begin
         pending_d = 1'b0;
      end else if (!pending_q && commit_req_i) begin
         pending_d = 1'b1;
      end
   end

   assign wr_err_d = wr_fire && !wr_in_range;

   // ------------------------------------------------------------------
   // Bank next state. Writes are blocked while pending, and a swap only
   // happens while pending, so the two branches never compete.
   // ------------------------------------------------------------------
   always_comb begin
      bank_d = bank_q;
      if (swap) begin
         // The old front becomes the new back; refresh it with the image
         // being published so later incremental writes edit what is shown.
         for (int l = 0; l < NUM_LEDS; l++) begin
            for (int c = 0; c < 3; c++) begin
               bank_d[front_q][l][c] = bank_q[back][l][c];
            end
         end
      end else if (wr_fire && wr_in_range) begin
         for (int l = 0; l < NUM_LEDS; l++) begin
            if (wr_led_i == 4'(l)) begin
               bank_d[back][l][0] = wr_r_i;
               bank_d[back][l][1] = wr_g_i;
               bank_d[back][l][2] = wr_b_i;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: pick the front-bank byte wired to the current sink.
   // ------------------------------------------------------------------
   always_comb begin
      logic [1:0] code;
      for (int l = 0; l < NUM_LEDS; l++) begin
         sel_d[l] = 8'd0;
         case (rd_chan_i)
            2'd0:    code = CHAN_MAP[6*l +: 2];
            2'd1:    code = CHAN_MAP[6*l+2 +: 2];
            2'd2:    code = CHAN_MAP[6*l+4 +: 2];
            default: code = 2'd3;
         endcase
         case (code)
            2'd0:    sel_d[l] = bank_q[front_q][l][0];
            2'd1:    sel_d[l] = bank_q[front_q][l][1];
            2'd2:    sel_d[l] = bank_q[front_q][l][2];
            default: sel_d[l] = 8'd0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: brightness scale, (v * (bright+1)) >> 8. Using bright+1
   // makes 255 an exact identity and 0 fully dark; the product never
   // exceeds 255*256, so 16 bits are enough.
   // ------------------------------------------------------------------
   always_comb begin
      logic [15:0] bright_p1;
      bright_p1 = {8'd0, bright_q} + 16'd1;
      level_d   = '0;
      for (int l = 0; l < NUM_LEDS; l++) begin
         level_d[8*l +: 8] = 8'(({8'd0, sel_q[l]} * bright_p1) >> 8);
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         front_q      <= 1'b0;
         pending_q    <= 1'b0;
         wr_err_q     <= 1'b0;
         commit_ack_q <= 1'b0;
         bright_q     <= 8'd0;
         level_q      <= '0;
         for (int l = 0; l < NUM_LEDS; l++) begin
            sel_q[l] <= 8'd0;
            for (int c = 0; c < 3; c++) begin
               bank_q[0][l][c] <= 8'd0;
               bank_q[1][l][c] <= 8'd0;
            end
         end
      end else begin
         if (swap) begin
            front_q <= ~front_q;
         end
         pending_q    <= pending_d;
         wr_err_q     <= wr_err_d;
         commit_ack_q <= swap;
         bright_q     <= bright_i;
         level_q      <= level_d;
         bank_q       <= bank_d;
         for (int l = 0; l < NUM_LEDS; l++) begin
            sel_q[l] <= sel_d[l];
         end
      end
   end

endmodule

// File: tb/tb_led_color_buffer.sv
// Directed bench for led_color_buffer.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: exercises writes and commits against a pending commit.
module tb_led_color_buffer;

   localparam int N = 11;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           wr_valid_i;
   logic           wr_ready_o;
   logic [3:0]     wr_led_i;
   logic [7:0]     wr_r_i, wr_g_i, wr_b_i;
   logic           wr_err_o;
   logic           commit_req_i;
   logic           commit_ack_o;
   logic           frame_start_i;
   logic [1:0]     rd_chan_i;
   logic [7:0]     bright_i;
   logic [8*N-1:0] level_bus_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected level per LED for the current rd_chan / bright.
   logic [7:0] exp_lvl [N];

   led_color_buffer dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .wr_valid_i    (wr_valid_i),
      .wr_ready_o    (wr_ready_o),
      .wr_led_i      (wr_led_i),
      .wr_r_i        (wr_r_i),
      .wr_g_i        (wr_g_i),
      .wr_b_i        (wr_b_i),
      .wr_err_o      (wr_err_o),
      .commit_req_i  (commit_req_i),
      .commit_ack_o  (commit_ack_o),
      .frame_start_i (frame_start_i),
      .rd_chan_i     (rd_chan_i),
      .bright_i      (bright_i),
      .level_bus_o   (level_bus_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [8*N-1:0] exp_bus();
      logic [8*N-1:0] v;
      for (int l = 0; l < N; l++) v[8*l +: 8] = exp_lvl[l];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [3:0] led, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic with_commit);
      wr_valid_i   = 1'b1;
      wr_led_i     = led;
      wr_r_i       = r;
      wr_g_i       = g;
      wr_b_i       = b;
      commit_req_i = with_commit;
      tick();
      wr_valid_i   = 1'b0;
      commit_req_i = 1'b0;
   endtask

   task automatic do_frame();
      frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
   endtask

   // Write + commit, swap at the next frame, wait for the read pipeline.
   task automatic publish(input logic [3:0] led, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
      do_write(led, r, g, b, 1'b1);
      do_frame();
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      wr_valid_i = 0; wr_led_i = 0; wr_r_i = 0; wr_g_i = 0; wr_b_i = 0;
      commit_req_i = 0; frame_start_i = 0; rd_chan_i = 2'd0; bright_i = 8'hFF;
      for (int l = 0; l < N; l++) exp_lvl[l] = 8'h00;
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      n_checks++;
      if (wr_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready_o);
      end
      n_checks++;
      if (wr_err_o !== 1'b0 || commit_ack_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses got err=%b ack=%b want 0/0", wr_err_o, commit_ack_o);
      end
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL reset_level got=%h want=%h", level_bus_o, exp_bus());
      end
   endtask

   task automatic test_first_commit();
      do_write(4'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
      commit_req_i = 1'b1;
      tick();
      commit_req_i = 1'b0;
      do_frame();
      n_checks++;
      if (commit_ack_o !== 1'b1) begin
         n_fail++; $display("FAIL first_ack got=%b want=1", commit_ack_o);
      end
      tick();
      n_checks++;
      if (commit_ack_o !== 1'b0 || level_bus_o[7:0] !== 8'h00) begin
         n_fail++; $display("FAIL first_edge1 got ack=%b lvl0=%h want 0/00", commit_ack_o, level_bus_o[7:0]);
      end
      tick();
      exp_lvl[0] = 8'hFF;
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL first_level got=%h want=%h", level_bus_o, exp_bus());
      end
   endtask

   task automatic test_wiring();
      logic [7:0] led0_by_chan [4];
      logic [7:0] led1_by_chan [4];
      led0_by_chan = '{8'hFF, 8'h00, 8'h00, 8'h00};
      led1_by_chan = '{8'h33, 8'h22, 8'h11, 8'h00};
      publish(4'd1, 8'h11, 8'h22, 8'h33);
      for (int ch = 0; ch < 4; ch++) begin
         rd_chan_i = 2'(ch);
         tick();
         tick();
         exp_lvl[0] = led0_by_chan[ch];
         exp_lvl[1] = led1_by_chan[ch];
         n_checks++;
         if (level_bus_o !== exp_bus()) begin
            n_fail++; $display("FAIL wiring_chan%0d got=%h want=%h", ch, level_bus_o, exp_bus());
         end
      end
      rd_chan_i = 2'd0;
      tick();
      tick();
      exp_lvl[0] = 8'hFF;
      exp_lvl[1] = 8'h33;
   endtask

   task automatic test_hold();
      int acks = 0;
      do_write(4'd2, 8'h44, 8'h55, 8'h66, 1'b1);
      n_checks++;
      if (wr_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL hold_wr_ready got=%b want=0", wr_ready_o);
      end
      // Refused write and a second commit while pending must both vanish.
      do_write(4'd2, 8'h99, 8'h99, 8'h99, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (commit_ack_o) acks++;
      end
      n_checks++;
      if (acks != 0) begin
         n_fail++; $display("FAIL hold_no_ack got=%0d want=0", acks);
      end
      n_checks++;
      if (level_bus_o !== exp_bus() || wr_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL hold_frozen got=%h rdy=%b want=%h rdy=0", level_bus_o, wr_ready_o, exp_bus());
      end
      do_frame();
      n_checks++;
      if (commit_ack_o !== 1'b1 || wr_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL hold_swap got ack=%b rdy=%b want 1/1", commit_ack_o, wr_ready_o);
      end
      tick();
      do_frame();
      n_checks++;
      if (commit_ack_o !== 1'b0) begin
         n_fail++; $display("FAIL hold_single_ack got=%b want=0", commit_ack_o);
      end
      tick();
      tick();
      exp_lvl[2] = 8'h44;
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL hold_level got=%h want=%h", level_bus_o, exp_bus());
      end
   endtask

   task automatic test_err();
      do_write(4'd11, 8'hAA, 8'hAA, 8'hAA, 1'b0);
      n_checks++;
      if (wr_err_o !== 1'b1) begin
         n_fail++; $display("FAIL err_led11 got=%b want=1", wr_err_o);
      end
      tick();
      n_checks++;
      if (wr_err_o !== 1'b0) begin
         n_fail++; $display("FAIL err_clear got=%b want=0", wr_err_o);
      end
      do_write(4'd15, 8'hAA, 8'hAA, 8'hAA, 1'b0);
      n_checks++;
      if (wr_err_o !== 1'b1) begin
         n_fail++; $display("FAIL err_led15 got=%b want=1", wr_err_o);
      end
      do_write(4'd2, 8'h77, 8'h88, 8'h99, 1'b1);
      n_checks++;
      if (wr_err_o !== 1'b0 || wr_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL err_inrange got err=%b rdy=%b want 0/0", wr_err_o, wr_ready_o);
      end
      do_frame();
      tick();
      tick();
      exp_lvl[2] = 8'h77;
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL err_same_cycle got=%h want=%h", level_bus_o, exp_bus());
      end
   endtask

   task automatic test_bright();
      publish(4'd0, 8'h80, 8'h00, 8'h00);
      exp_lvl[0] = 8'h80;
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL bright_ff got=%h want=%h", level_bus_o, exp_bus());
      end
      bright_i = 8'h7F;
      tick();
      n_checks++;
      if (level_bus_o[7:0] !== 8'h80) begin
         n_fail++; $display("FAIL bright_lag got=%h want=80", level_bus_o[7:0]);
      end
      tick();
      n_checks++;
      if (level_bus_o[7:0] !== 8'h40 || level_bus_o[15:8] !== 8'h19 || level_bus_o[23:16] !== 8'h3B) begin
         n_fail++; $display("FAIL bright_7f got=%h_%h_%h want=3b_19_40",
                            level_bus_o[23:16], level_bus_o[15:8], level_bus_o[7:0]);
      end
      bright_i = 8'h00;
      tick();
      tick();
      n_checks++;
      if (level_bus_o !== '0) begin
         n_fail++; $display("FAIL bright_00 got=%h want=0", level_bus_o);
      end
      bright_i = 8'hFF;
      tick();
      tick();
   endtask

   task automatic test_simultaneous();
      wr_valid_i = 1'b1; wr_led_i = 4'd6; wr_r_i = 8'h00; wr_g_i = 8'h00; wr_b_i = 8'h3C;
      commit_req_i = 1'b1; frame_start_i = 1'b1;
      tick();
      wr_valid_i = 1'b0; commit_req_i = 1'b0; frame_start_i = 1'b0;
      n_checks++;
      if (commit_ack_o !== 1'b0 || wr_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL simul_no_swap got ack=%b rdy=%b want 0/0", commit_ack_o, wr_ready_o);
      end
      tick();
      do_frame();
      n_checks++;
      if (commit_ack_o !== 1'b1) begin
         n_fail++; $display("FAIL simul_ack got=%b want=1", commit_ack_o);
      end
      tick();
      tick();
      exp_lvl[6] = 8'h3C;
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL simul_level got=%h want=%h", level_bus_o, exp_bus());
      end
   endtask

   task automatic test_copy_and_reset();
      publish(4'd3, 8'h01, 8'h02, 8'h5A);
      exp_lvl[3] = 8'h5A;
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL copy_on_swap got=%h want=%h", level_bus_o, exp_bus());
      end
      do_write(4'd4, 8'h12, 8'h34, 8'h56, 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      for (int l = 0; l < N; l++) exp_lvl[l] = 8'h00;
      n_checks++;
      if (level_bus_o !== exp_bus() || wr_ready_o !== 1'b1 || commit_ack_o !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got=%h rdy=%b ack=%b want 0 1 0", level_bus_o, wr_ready_o, commit_ack_o);
      end
      tick();
      rst_i = 1'b0;
      do_frame();
      n_checks++;
      if (commit_ack_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_drops_pending got=%b want=0", commit_ack_o);
      end
      tick();
      tick();
      n_checks++;
      if (level_bus_o !== exp_bus()) begin
         n_fail++; $display("FAIL reset_clears_banks got=%h want=%h", level_bus_o, exp_bus());
      end
   endtask

   initial begin
      test_reset();
      test_first_commit();
      test_wiring();
      test_hold();
      test_err();
      test_bright();
      test_simultaneous();
      test_copy_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
